// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode encodings and instruction classes shared by the pipeline controllers.
package cpu_pkg;
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_NOP   = 4'b1010;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_BPZ   = 4'b1101;
  localparam logic [2:0] SFX_SHIFT = 3'b011;
  localparam logic [2:0] SFX_ORI   = 3'b111;
  localparam logic [3:0] NOP_ENC   = OP_NOP;
  typedef enum logic [3:0] {ARITH, SHIFT, ORI, LOAD, STORE, BZ, BNZ, BPZ, NOP, STOP} instr_class_e;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: classifies an 8-bit instruction by its opcode field.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0]   ir,
  output instr_class_e cls
);
  logic unused_regs;
  assign unused_regs = ^ir[7:4];
  always_comb begin
    cls = NOP;
    case (ir[3:0])
      OP_LOAD:                 cls = LOAD;
      OP_STOP:                 cls = STOP;
      OP_STORE:                cls = STORE;
      OP_ADD, OP_SUB, OP_NAND: cls = ARITH;
      OP_BZ:                   cls = BZ;
      OP_BNZ:                  cls = BNZ;
      OP_BPZ:                  cls = BPZ;
      default:                 cls = ir[2:0] == SFX_SHIFT ? SHIFT : ir[2:0] == SFX_ORI ? ORI : NOP;
    endcase
  end
endmodule

// File: rtl/ex_wb_controller.sv
// ex_wb_controller: execute/writeback control -- branch resolution, squash window, memory and RF writes, halt.
module ex_wb_controller
  import cpu_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2,
  parameter int KREG          = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] IR3Out,
  input  logic [7:0] IR4Out,
  input  logic       Z,
  input  logic       N,
  output logic       PCWrite,
  output logic       PCSel,
  output logic       IRFlush,
  output logic       branching,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RFWrite,
  output logic [1:0] RegWSel,
  output logic       RegInSel,
  output logic       halted
);
  localparam int SW = $clog2(SQUASH_CYCLES + 1);
  typedef enum logic [1:0] {RUN, SQUASH, HALT} state_e;
  state_e       state;
  logic [SW-1:0] sq_cnt;
  instr_class_e c3, c4;
  logic         live, stop4, taken;
  instr_decode u_dec3 (.ir(IR3Out), .cls(c3));
  instr_decode u_dec4 (.ir(IR4Out), .cls(c4));
  // Outputs are forced low while reset is held, independent of any clock edge.
  assign live  = reset && state != HALT;
  assign stop4 = c4 == STOP;
  assign taken = state == RUN && ((c3 == BZ && Z) || (c3 == BNZ && !Z) || (c3 == BPZ && !N));
  always_comb begin
    PCWrite  = live && !stop4;
    PCSel    = PCWrite && taken;
    IRFlush  = PCWrite && taken;
    MemRead  = PCWrite && c3 == LOAD;
    MemWrite = PCWrite && c3 == STORE;
    RFWrite  = live && (c4 inside {ARITH, SHIFT, ORI, LOAD});
    RegWSel  = !RFWrite ? 2'b00 : c4 == ORI ? 2'(KREG) : IR4Out[7:6];
    RegInSel = live && c4 == LOAD;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      sq_cnt    <= '0;
      halted    <= 1'b0;
      branching <= 1'b0;
    end else if (state != HALT) begin
      if (stop4) begin
        state     <= HALT;
        sq_cnt    <= '0;
        halted    <= 1'b1;
        branching <= 1'b0;
      end else if (taken) begin
        state     <= SQUASH;
        sq_cnt    <= SW'(SQUASH_CYCLES - 1);
        branching <= 1'b1;
      end else if (state == SQUASH) begin
        if (sq_cnt == '0) begin
          state     <= RUN;
          branching <= 1'b0;
        end else begin
          sq_cnt <= sq_cnt - SW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_wb_controller.sv
// tb_ex_wb_controller: directed and randomized checks against a cycle-level behavioural model.
module tb_ex_wb_controller;
  localparam int SQ = 2;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] IR3Out, IR4Out;
  logic       Z, N;
  logic       PCWrite, PCSel, IRFlush, branching, MemRead, MemWrite, RFWrite, RegInSel, halted;
  logic [1:0] RegWSel;
  int total = 0;
  int bad = 0;
  int sq_left = 0, nsq = 0;
  bit hlt = 0, nh = 0;
  int hcnt = 0;
  logic [3:0] ops [5] = '{4'h5, 4'h9, 4'hD, 4'h0, 4'h2};

  ex_wb_controller #(.SQUASH_CYCLES(SQ), .KREG(1)) dut (
    .clock(clock), .reset(reset), .IR3Out(IR3Out), .IR4Out(IR4Out), .Z(Z), .N(N),
    .PCWrite(PCWrite), .PCSel(PCSel), .IRFlush(IRFlush), .branching(branching),
    .MemRead(MemRead), .MemWrite(MemWrite), .RFWrite(RFWrite), .RegWSel(RegWSel),
    .RegInSel(RegInSel), .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs derived directly from the opcode table and the squash/halt rules.
  task automatic check_all();
    logic [3:0] o3, o4;
    logic act, stp, tk, pcw, rfw;
    logic [1:0] ws;
    o3  = IR3Out[3:0];
    o4  = IR4Out[3:0];
    act = reset && !hlt;
    stp = o4 == 4'h1;
    tk  = act && sq_left == 0 && ((o3 == 4'h5 && Z) || (o3 == 4'h9 && !Z) || (o3 == 4'hD && !N));
    pcw = act && !stp;
    rfw = act && ((o4 inside {4'h0, 4'h4, 4'h6, 4'h8}) || (IR4Out[2:0] inside {3'b011, 3'b111}));
    ws  = !rfw ? 2'd0 : IR4Out[2:0] == 3'b111 ? 2'd1 : IR4Out[7:6];
    chk("PCWrite", 8'(PCWrite), 8'(pcw));
    chk("PCSel", 8'(PCSel), 8'(pcw && tk));
    chk("IRFlush", 8'(IRFlush), 8'(pcw && tk));
    chk("MemRead", 8'(MemRead), 8'(pcw && o3 == 4'h0));
    chk("MemWrite", 8'(MemWrite), 8'(pcw && o3 == 4'h2));
    chk("RFWrite", 8'(RFWrite), 8'(rfw));
    chk("RegWSel", 8'(RegWSel), 8'(ws));
    chk("RegInSel", 8'(RegInSel), 8'(act && o4 == 4'h0));
    chk("branching", 8'(branching), 8'(reset && sq_left > 0));
    chk("halted", 8'(halted), 8'(reset && hlt));
    nsq = sq_left;
    nh  = hlt;
    if (!reset) begin
      nsq = 0;
      nh  = 0;
    end else if (!hlt) begin
      if (stp) begin
        nh  = 1;
        nsq = 0;
      end else if (tk) nsq = SQ;
      else if (sq_left > 0) nsq = sq_left - 1;
    end
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic z, input logic n);
    IR3Out = a;
    IR4Out = b;
    Z = z;
    N = n;
    #2;
    check_all();
    @(posedge clock);
    sq_left = nsq;
    hlt = nh;
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    sq_left = 0;
    hlt = 0;
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] r3, r4;
    reset = 1'b0;
    IR3Out = 8'h05;
    IR4Out = 8'h0A;
    Z = 1'b1;
    N = 1'b0;
    @(posedge clock);
    #2;
    check_all();
    chk("rst_pcw", 8'(PCWrite), 8'h00);
    @(negedge clock);
    reset = 1'b1;
    step(8'h0A, 8'h0A, 1'b0, 1'b0);
    chk("run_pcw", 8'(PCWrite), 8'h01);
    step(8'h05, 8'h0A, 1'b1, 1'b0);
    chk("sq_br1", 8'(branching), 8'h01);
    step(8'h0A, 8'h0A, 1'b0, 1'b0);
    chk("sq_br2", 8'(branching), 8'h01);
    step(8'h05, 8'h0A, 1'b1, 1'b0);
    chk("sq_end", 8'(branching), 8'h00);
    step(8'h09, 8'h0A, 1'b1, 1'b0);
    step(8'h0D, 8'h0A, 1'b0, 1'b1);
    step(8'h00, 8'h64, 1'b0, 1'b0);
    step(8'h02, 8'h80, 1'b0, 1'b0);
    step(8'h0A, 8'h07, 1'b0, 1'b0);
    step(8'h0A, 8'h12, 1'b0, 1'b0);
    step(8'h05, 8'h01, 1'b1, 1'b0);
    chk("halted", 8'(halted), 8'h01);
    for (int i = 0; i < 10; i++) step(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    pulse_reset();
    step(8'h05, 8'h0A, 1'b1, 1'b0);
    chk("br_in", 8'(branching), 8'h01);
    reset = 1'b0;
    sq_left = 0;
    hlt = 0;
    #1;
    chk("async_br", 8'(branching), 8'h00);
    check_all();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0 || hcnt > 4) begin
        pulse_reset();
        hcnt = 0;
      end
      r3 = 8'($urandom);
      if ($urandom_range(0, 1) == 1) r3[3:0] = ops[$urandom_range(0, 4)];
      r4 = 8'($urandom);
      if (r4[3:0] == 4'h1 && $urandom_range(0, 9) != 0) r4[3:0] = 4'hA;
      step(r3, r4, 1'($urandom), 1'($urandom));
      if (hlt) hcnt++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
